vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 93 +++++++++
 tb/tb_vga_sync_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides the system clock down to a pixel strobe and
// produces pixel/line counters with zero-skew registered sync, enable and frame pulses.
module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits wide so an end bound of 1024 still compares correctly.
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             div_wrap;
    logic             h_wrap;
    logic [9:0]       h_next;
    logic [9:0]       v_next;

    function automatic logic sync_level(input logic [9:0]  cnt,
                                        input logic [10:0] lo,
                                        input logic [10:0] hi);
        return !(({1'b0, cnt} >= lo) && ({1'b0, cnt} < hi));
    endfunction

    function automatic logic visible(input logic [9:0] h, input logic [9:0] v);
        return ({1'b0, h} < H_VIS) && ({1'b0, v} < V_VIS);
    endfunction

    always_comb begin
        div_wrap = (div == DIV_LAST);
        h_wrap   = (hcount == H_LAST);
        h_next   = h_wrap ? 10'd0 : hcount + 10'd1;
        v_next   = vcount;
        if (h_wrap) begin
            v_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end
    end

    // Decode uses the next counter values so the flags land with their counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            pix_en      <= 1'b0;
            hcount      <= H_LAST;
            vcount      <= V_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= div_wrap;
            div         <= div_wrap ? '0 : div + DIV_W'(1);
            frame_start <= 1'b0;
            if (div_wrap) begin
                hcount      <= h_next;
                vcount      <= v_next;
                hsync       <= sync_level(h_next, HS_START, HS_END);
                vsync       <= sync_level(v_next, VS_START, VS_END);
                de          <= visible(h_next, v_next);
                frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing plus two small geometries (pixel divide 1 and 3),
// a per-clock scoreboard against a strobe-index model, a vector table and a mid-frame reset.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       a_pe, a_hs, a_vs, a_de, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_pe, b_hs, b_vs, b_de, b_fs;
    logic [9:0] b_h, b_v;
    logic       c_pe, c_hs, c_vs, c_de, c_fs;
    logic [9:0] c_h, c_v;

    vga_sync_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(a_pe), .hcount(a_h), .vcount(a_v),
        .hsync(a_hs), .vsync(a_vs), .de(a_de), .frame_start(a_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_en(b_pe), .hcount(b_h), .vcount(b_v),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .frame_start(b_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .pix_en(c_pe), .hcount(c_h), .vcount(c_v),
        .hsync(c_hs), .vsync(c_vs), .de(c_de), .frame_start(c_fs)
    );

    typedef struct {
        logic       pe;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs, vs, de, fs;
    } exp_t;

    typedef struct {
        int t, h, v, pe, hs, vs, de, fs;
    } vec_t;

    exp_t q_a[$], q_b[$], q_c[$];
    vec_t tbl[14];

    int t = 0;
    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int hs_low = 0, de_high = 0;
    int last_fs_b = -1, last_fs_c = -1, n_fs_b = 0, n_fs_c = 0;
    logic [22:0] prev_a, prev_b, prev_c;
    bit ok_a = 0, ok_b = 0, ok_c = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", n, act, expv);
    endtask

    // Expected outputs from the strobe index since release, not from counter stepping.
    function automatic exp_t model(input int cd, input int ha, input int hfp, input int hsw,
                                   input int hbp, input int va, input int vfp, input int vsw,
                                   input int vbp, input int tt);
        exp_t e;
        int ht, vt, k, h, v;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        if (tt < cd) begin
            e.pe = 1'b0; e.h = 10'(ht - 1); e.v = 10'(vt - 1);
            e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fs = 1'b0;
        end else begin
            k = tt / cd - 1;
            h = k % ht;
            v = (k / ht) % vt;
            e.pe = (tt % cd == 0);
            e.h  = 10'(h);
            e.v  = 10'(v);
            e.hs = !(h >= ha + hfp && h < ha + hfp + hsw);
            e.vs = !(v >= va + vfp && v < va + vfp + vsw);
            e.de = (h < ha) && (v < va);
            e.fs = e.pe && h == 0 && v == 0;
        end
        return e;
    endfunction

    task automatic cmp(input string n, input exp_t e, input logic pe, input logic [9:0] h,
                       input logic [9:0] v, input logic hs, input logic vs, input logic de,
                       input logic fs);
        chk($sformatf("%s.pix_en@%0d", n, cyc), 32'(pe), 32'(e.pe));
        chk($sformatf("%s.hcount@%0d", n, cyc), 32'(h), 32'(e.h));
        chk($sformatf("%s.vcount@%0d", n, cyc), 32'(v), 32'(e.v));
        chk($sformatf("%s.hsync@%0d", n, cyc), 32'(hs), 32'(e.hs));
        chk($sformatf("%s.vsync@%0d", n, cyc), 32'(vs), 32'(e.vs));
        chk($sformatf("%s.de@%0d", n, cyc), 32'(de), 32'(e.de));
        chk($sformatf("%s.frame_start@%0d", n, cyc), 32'(fs), 32'(e.fs));
    endtask

    task automatic inv(input string n, input int ht, input int vt, input int ha, input int hfp,
                       input int hsw, input int va, input int vfp, input int vsw,
                       input logic pe, input logic [9:0] h, input logic [9:0] v,
                       input logic hs, input logic vs, input logic de,
                       input logic [22:0] prev, input bit prev_ok);
        int hi, vi;
        hi = int'(h);
        vi = int'(v);
        chk($sformatf("%s.h_range@%0d", n, cyc), 32'(hi < ht), 32'd1);
        chk($sformatf("%s.v_range@%0d", n, cyc), 32'(vi < vt), 32'd1);
        chk($sformatf("%s.hs_decode@%0d", n, cyc), 32'(hs),
            32'(!(hi >= ha + hfp && hi < ha + hfp + hsw)));
        chk($sformatf("%s.vs_decode@%0d", n, cyc), 32'(vs),
            32'(!(vi >= va + vfp && vi < va + vfp + vsw)));
        chk($sformatf("%s.de_decode@%0d", n, cyc), 32'(de), 32'((hi < ha) && (vi < va)));
        if (rst_n && prev_ok && !pe)
            chk($sformatf("%s.hold@%0d", n, cyc), 32'({h, v, hs, vs, de}), 32'(prev));
    endtask

    // Scoreboard: push the expectation at each active edge, compare at the falling edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) t = 0;
        else t = t + 1;
        q_a.push_back(model(4, 640, 16, 96, 48, 480, 10, 2, 33, t));
        q_b.push_back(model(1, 8, 2, 2, 2, 4, 1, 1, 1, t));
        q_c.push_back(model(3, 8, 2, 2, 2, 4, 1, 1, 1, t));
    end

    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            cmp("a", e, a_pe, a_h, a_v, a_hs, a_vs, a_de, a_fs);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            cmp("b", e, b_pe, b_h, b_v, b_hs, b_vs, b_de, b_fs);
        end
        if (q_c.size() > 0) begin
            e = q_c.pop_front();
            cmp("c", e, c_pe, c_h, c_v, c_hs, c_vs, c_de, c_fs);
        end
        inv("a", 800, 525, 640, 16, 96, 480, 10, 2, a_pe, a_h, a_v, a_hs, a_vs, a_de, prev_a, ok_a);
        inv("b", 14, 7, 8, 2, 2, 4, 1, 1, b_pe, b_h, b_v, b_hs, b_vs, b_de, prev_b, ok_b);
        inv("c", 14, 7, 8, 2, 2, 4, 1, 1, c_pe, c_h, c_v, c_hs, c_vs, c_de, prev_c, ok_c);
        prev_a = {a_h, a_v, a_hs, a_vs, a_de};
        prev_b = {b_h, b_v, b_hs, b_vs, b_de};
        prev_c = {c_h, c_v, c_hs, c_vs, c_de};
        ok_a = rst_n; ok_b = rst_n; ok_c = rst_n;
        if (!rst_n) begin
            hs_low = 0; de_high = 0; last_fs_b = -1; last_fs_c = -1;
        end else begin
            if (a_pe && !a_hs && a_v == 10'd0) hs_low++;
            if (a_pe && a_de && a_v == 10'd0) de_high++;
            if (b_fs) begin
                if (last_fs_b >= 0) chk($sformatf("b.fs_period@%0d", cyc), 32'(cyc - last_fs_b), 32'd98);
                last_fs_b = cyc; n_fs_b++;
            end
            if (c_fs) begin
                if (last_fs_c >= 0) chk($sformatf("c.fs_period@%0d", cyc), 32'(cyc - last_fs_c), 32'd294);
                last_fs_c = cyc; n_fs_c++;
            end
        end
    end

    task automatic check_reset_now(input string n);
        chk({n, ".rst_hcount"}, 32'(a_h), 32'd799);
        chk({n, ".rst_vcount"}, 32'(a_v), 32'd524);
        chk({n, ".rst_pix_en"}, 32'(a_pe), 32'd0);
        chk({n, ".rst_frame_start"}, 32'(a_fs), 32'd0);
        chk({n, ".rst_hsync"}, 32'(a_hs), 32'd1);
        chk({n, ".rst_vsync"}, 32'(a_vs), 32'd1);
        chk({n, ".rst_de"}, 32'(a_de), 32'd0);
        chk({n, ".rst_b_hcount"}, 32'(b_h), 32'd13);
        chk({n, ".rst_c_vcount"}, 32'(c_v), 32'd6);
    endtask

    task automatic run_table(input string n);
        for (int i = 0; i < 14; i++) begin
            int guard;
            guard = 0;
            do begin
                @(negedge clk);
                #1;
                guard++;
            end while (t < tbl[i].t && guard < 5000);
            chk($sformatf("%s.tbl%0d.time", n, i), 32'(t), 32'(tbl[i].t));
            chk($sformatf("%s.tbl%0d.pix_en", n, i), 32'(a_pe), 32'(tbl[i].pe));
            chk($sformatf("%s.tbl%0d.hcount", n, i), 32'(a_h), 32'(tbl[i].h));
            chk($sformatf("%s.tbl%0d.vcount", n, i), 32'(a_v), 32'(tbl[i].v));
            chk($sformatf("%s.tbl%0d.hsync", n, i), 32'(a_hs), 32'(tbl[i].hs));
            chk($sformatf("%s.tbl%0d.vsync", n, i), 32'(a_vs), 32'(tbl[i].vs));
            chk($sformatf("%s.tbl%0d.de", n, i), 32'(a_de), 32'(tbl[i].de));
            chk($sformatf("%s.tbl%0d.frame_start", n, i), 32'(a_fs), 32'(tbl[i].fs));
        end
        chk({n, ".line0_hsync_low_strobes"}, 32'(hs_low), 32'd96);
        chk({n, ".line0_de_strobes"}, 32'(de_high), 32'd640);
    endtask

    initial begin
        int guard;
        //          t     h    v   pe hs vs de fs
        tbl[0]  = '{1,    799, 524, 0, 1, 1, 0, 0};
        tbl[1]  = '{3,    799, 524, 0, 1, 1, 0, 0};
        tbl[2]  = '{4,    0,   0,   1, 1, 1, 1, 1};
        tbl[3]  = '{5,    0,   0,   0, 1, 1, 1, 0};
        tbl[4]  = '{8,    1,   0,   1, 1, 1, 1, 0};
        tbl[5]  = '{2560, 639, 0,   1, 1, 1, 1, 0};
        tbl[6]  = '{2563, 639, 0,   0, 1, 1, 1, 0};
        tbl[7]  = '{2564, 640, 0,   1, 1, 1, 0, 0};
        tbl[8]  = '{2624, 655, 0,   1, 1, 1, 0, 0};
        tbl[9]  = '{2628, 656, 0,   1, 0, 1, 0, 0};
        tbl[10] = '{3008, 751, 0,   1, 0, 1, 0, 0};
        tbl[11] = '{3012, 752, 0,   1, 1, 1, 0, 0};
        tbl[12] = '{3200, 799, 0,   1, 1, 1, 0, 0};
        tbl[13] = '{3204, 0,   1,   1, 1, 1, 1, 0};

        #1 rst_n = 1'b0;
        #1 check_reset_now("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_table("first");

        // Mid-frame reset at (300,1), dropped between clock edges.
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (!(a_h == 10'd300 && a_v == 10'd1) && guard < 3000);
        chk("mid.reached_300_1", 32'({a_h, a_v}), 32'({10'd300, 10'd1}));
        #1 rst_n = 1'b0;
        #1 check_reset_now("mid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_table("second");

        chk("b.frames_seen", 32'(n_fs_b >= 10), 32'd1);
        chk("c.frames_seen", 32'(n_fs_c >= 3), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
